vdu_timing_gen: RTL and testbench

//  Raster timing generator for the VDU path, downstream of the sysclk pixel-enable divider.

---
 rtl/vdu_timing_pkg.sv | 33 +++
 rtl/vdu_axis_counter.sv | 40 ++++
 rtl/vdu_timing_gen.sv | 95 +++++++++
 tb/tb_vdu_timing_gen.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdu_timing_pkg.sv
// Default 640x480@60 raster constants and helpers shared by the timing generator
// and the pixel/scope renderer.
package vdu_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync windows start right after the front porch; renderer uses the same bounds.
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int VS_START = V_ACTIVE + V_FP;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
        logic line_start;
        logic frame_start;
    } vdu_ctl_t;

    function automatic logic in_window(input int val, input int lo, input int len);
        return (val >= lo) && (val < lo + len);
    endfunction

endpackage

// File: rtl/vdu_axis_counter.sv
// Wrapping raster axis counter: counts 0..MAX on enable, resets to MAX so the
// first enable lands on 0. Exposes the next value for same-edge decodes.
module vdu_axis_counter #(
    parameter int MAX = 799,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_next,
    output logic         o_wrap
);

    logic [W-1:0] r_count;
    logic [W-1:0] w_next;
    logic         w_wrap;

    assign w_wrap = (r_count == W'(MAX));

    always_comb begin
        w_next = r_count;
        if (i_en) begin
            w_next = w_wrap ? '0 : r_count + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= W'(MAX);
        end else begin
            r_count <= w_next;
        end
    end

    assign o_count = r_count;
    assign o_next  = w_next;
    assign o_wrap  = w_wrap;

endmodule

// File: rtl/vdu_timing_gen.sv
// Raster timing generator: advances h/v counters on each pix_en pulse and produces
// registered sync, blanking and line/frame strobes aligned with the counters.
module vdu_timing_gen #(
    parameter int   H_ACTIVE = vdu_timing_pkg::H_ACTIVE,
    parameter int   H_FP     = vdu_timing_pkg::H_FP,
    parameter int   H_SYNC   = vdu_timing_pkg::H_SYNC,
    parameter int   H_BP     = vdu_timing_pkg::H_BP,
    parameter int   V_ACTIVE = vdu_timing_pkg::V_ACTIVE,
    parameter int   V_FP     = vdu_timing_pkg::V_FP,
    parameter int   V_SYNC   = vdu_timing_pkg::V_SYNC,
    parameter int   V_BP     = vdu_timing_pkg::V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   HW       = 10,
    parameter int   VW       = 10
) (
    input  logic          sysclk,
    input  logic          rst_n,
    input  logic          pix_en,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          line_start,
    output logic          frame_start
);

    import vdu_timing_pkg::vdu_ctl_t;
    import vdu_timing_pkg::in_window;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_v_en;
    logic [HW-1:0] w_h_next;
    logic [VW-1:0] w_v_next;
    vdu_ctl_t      w_ctl_next;
    vdu_ctl_t      r_ctl;

    assign w_v_en = pix_en & w_h_wrap;

    vdu_axis_counter #(.MAX(H_TOTAL - 1), .W(HW)) u_h_counter (
        .clk     (sysclk),
        .rst_n   (rst_n),
        .i_en    (pix_en),
        .o_count (hcount),
        .o_next  (w_h_next),
        .o_wrap  (w_h_wrap)
    );

    vdu_axis_counter #(.MAX(V_TOTAL - 1), .W(VW)) u_v_counter (
        .clk     (sysclk),
        .rst_n   (rst_n),
        .i_en    (w_v_en),
        .o_count (vcount),
        .o_next  (w_v_next),
        .o_wrap  (w_v_wrap)
    );

    // Decode from the next counter values so the registered flags line up with hcount/vcount.
    always_comb begin
        w_ctl_next             = r_ctl;
        w_ctl_next.line_start  = 1'b0;
        w_ctl_next.frame_start = 1'b0;
        if (pix_en) begin
            w_ctl_next.hsync       = in_window(32'(w_h_next), H_ACTIVE + H_FP, H_SYNC) ? HS_POL : ~HS_POL;
            w_ctl_next.vsync       = in_window(32'(w_v_next), V_ACTIVE + V_FP, V_SYNC) ? VS_POL : ~VS_POL;
            w_ctl_next.video_on    = (32'(w_h_next) < H_ACTIVE) && (32'(w_v_next) < V_ACTIVE);
            w_ctl_next.line_start  = w_h_wrap;
            w_ctl_next.frame_start = w_h_wrap & w_v_wrap;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctl.hsync       <= ~HS_POL;
            r_ctl.vsync       <= ~VS_POL;
            r_ctl.video_on    <= 1'b0;
            r_ctl.line_start  <= 1'b0;
            r_ctl.frame_start <= 1'b0;
        end else begin
            r_ctl <= w_ctl_next;
        end
    end

    assign hsync       = r_ctl.hsync;
    assign vsync       = r_ctl.vsync;
    assign video_on    = r_ctl.video_on;
    assign line_start  = r_ctl.line_start;
    assign frame_start = r_ctl.frame_start;

endmodule

// File: tb/tb_vdu_timing_gen.sv
// Bench for vdu_timing_gen: a default 640x480 instance plus a tiny-geometry instance
// (full frames in a few hundred cycles), both checked every cycle against a pulse-count model.
module tb_vdu_timing_gen;

    logic       sysclk = 1'b0;
    logic       rst_n  = 1'b1;
    logic       pix_en = 1'b0;

    logic [9:0] d_hcount, d_vcount;
    logic       d_hsync, d_vsync, d_video_on, d_line_start, d_frame_start;
    logic [4:0] s_hcount;
    logic [3:0] s_vcount;
    logic       s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  mon_en   = 1'b0;

    always #5 sysclk = ~sysclk;

    vdu_timing_gen dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .hcount      (d_hcount),
        .vcount      (d_vcount),
        .hsync       (d_hsync),
        .vsync       (d_vsync),
        .video_on    (d_video_on),
        .line_start  (d_line_start),
        .frame_start (d_frame_start)
    );

    vdu_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1), .HW(5), .VW(4)
    ) dut_small (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .hcount      (s_hcount),
        .vcount      (s_vcount),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .video_on    (s_video_on),
        .line_start  (s_line_start),
        .frame_start (s_frame_start)
    );

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit hp, vp;
    } geom_t;

    typedef struct {
        int h, v;
        bit hs, vs, vid, ls, fs;
    } exp_t;

    typedef struct {
        int pulses;
        int h, v;
        bit hs, vs, vid, ls, fs;
    } vec_t;

    geom_t g_d, g_s;

    // Position is simply the number of accepted pulses since reset, starting one
    // pixel before (0,0) of the frame.
    function automatic exp_t model(input geom_t g, input int n, input bit prev);
        exp_t e;
        int ht, vt, fr, pos;
        ht  = g.ha + g.hf + g.hs + g.hb;
        vt  = g.va + g.vf + g.vs + g.vb;
        fr  = ht * vt;
        pos = ((n % fr) + fr - 1) % fr;
        e.h   = pos % ht;
        e.v   = pos / ht;
        e.hs  = (e.h >= g.ha + g.hf && e.h < g.ha + g.hf + g.hs) ? g.hp : !g.hp;
        e.vs  = (e.v >= g.va + g.vf && e.v < g.va + g.vf + g.vs) ? g.vp : !g.vp;
        e.vid = (e.h < g.ha) && (e.v < g.va);
        e.ls  = prev && (e.h == 0);
        e.fs  = e.ls && (e.v == 0);
        return e;
    endfunction

    int m_n;
    bit m_prev;

    initial begin
        m_n    = 0;
        m_prev = 1'b0;
    end

    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            m_n    <= 0;
            m_prev <= 1'b0;
        end else begin
            m_n    <= m_n + int'(pix_en);
            m_prev <= pix_en;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge sysclk) begin : monitor
        exp_t e;
        if (mon_en) begin
            e = model(g_d, m_n, m_prev);
            chk("mon.d.hcount", int'(d_hcount), e.h);
            chk("mon.d.vcount", int'(d_vcount), e.v);
            chk("mon.d.hsync", int'(d_hsync), int'(e.hs));
            chk("mon.d.vsync", int'(d_vsync), int'(e.vs));
            chk("mon.d.video_on", int'(d_video_on), int'(e.vid));
            chk("mon.d.line_start", int'(d_line_start), int'(e.ls));
            chk("mon.d.frame_start", int'(d_frame_start), int'(e.fs));
            e = model(g_s, m_n, m_prev);
            chk("mon.s.hcount", int'(s_hcount), e.h);
            chk("mon.s.vcount", int'(s_vcount), e.v);
            chk("mon.s.hsync", int'(s_hsync), int'(e.hs));
            chk("mon.s.vsync", int'(s_vsync), int'(e.vs));
            chk("mon.s.video_on", int'(s_video_on), int'(e.vid));
            chk("mon.s.line_start", int'(s_line_start), int'(e.ls));
            chk("mon.s.frame_start", int'(s_frame_start), int'(e.fs));
        end
    end

    task automatic chk_d(input string tag, input int h, input int v,
                         input bit hs, input bit vs, input bit vid, input bit ls, input bit fs);
        $display("txn %s: d h=%0d v=%0d hs=%0b vs=%0b vid=%0b ls=%0b fs=%0b", tag,
                 d_hcount, d_vcount, d_hsync, d_vsync, d_video_on, d_line_start, d_frame_start);
        chk({tag, ".hcount"}, int'(d_hcount), h);
        chk({tag, ".vcount"}, int'(d_vcount), v);
        chk({tag, ".hsync"}, int'(d_hsync), int'(hs));
        chk({tag, ".vsync"}, int'(d_vsync), int'(vs));
        chk({tag, ".video_on"}, int'(d_video_on), int'(vid));
        chk({tag, ".line_start"}, int'(d_line_start), int'(ls));
        chk({tag, ".frame_start"}, int'(d_frame_start), int'(fs));
    endtask

    task automatic chk_s_reset(input string tag);
        $display("txn %s: s h=%0d v=%0d hs=%0b vs=%0b", tag, s_hcount, s_vcount, s_hsync, s_vsync);
        chk({tag, ".s.hcount"}, int'(s_hcount), 15);
        chk({tag, ".s.vcount"}, int'(s_vcount), 11);
        chk({tag, ".s.hsync"}, int'(s_hsync), 0);
        chk({tag, ".s.vsync"}, int'(s_vsync), 0);
        chk({tag, ".s.video_on"}, int'(s_video_on), 0);
        chk({tag, ".s.strobes"}, int'({s_line_start, s_frame_start}), 0);
    endtask

    // All stimulus runs in the phase 1 time unit after a rising edge.
    task automatic idle(input int k);
        repeat (k) @(posedge sysclk);
        #1;
    endtask

    task automatic pulses(input int k);
        pix_en = 1'b1;
        repeat (k) @(posedge sysclk);
        #1;
        pix_en = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst_n  = 1'b0;
        pix_en = 1'b1;
        idle(3);
        pix_en = 1'b0;
        rst_n  = 1'b1;
    endtask

    vec_t vecs[9];

    initial begin
        int hs_low, ls_cnt, fs_cnt, vs_cnt, last_fs, gap;

        g_d = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
        g_s = '{8, 2, 3, 3, 6, 2, 2, 2, 1'b1, 1'b1};

        // pulses applied back-to-back, then outputs compared
        vecs[0] = '{0,   799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1,   0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{639, 639, 0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1,   640, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16,  656, 0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{95,  751, 0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1,   752, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{47,  799, 0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1,   0,   1,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        @(posedge sysclk);
        #1;
        #2;
        rst_n  = 1'b0;
        mon_en = 1'b1;
        pix_en = 1'b1;
        idle(3);
        chk_d("reset", 799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_s_reset("reset");
        pix_en = 1'b0;
        rst_n  = 1'b1;

        pulses(1);
        chk_d("first_pix", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1);
        chk_d("first_hold", 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].pulses > 0) pulses(vecs[i].pulses);
            chk_d($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs,
                  vecs[i].vid, vecs[i].ls, vecs[i].fs);
        end

        // One line at one pulse per 5 cycles
        hs_low = 0;
        ls_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            pulses(1);
            if (d_hsync == 1'b0) hs_low++;
            if (d_line_start) ls_cnt++;
            idle(4);
        end
        $display("txn line_div5: hs_low=%0d line_starts=%0d", hs_low, ls_cnt);
        chk("line_div5.hs_low", hs_low, 96);
        chk("line_div5.line_starts", ls_cnt, 1);
        chk("line_div5.hcount", int'(d_hcount), 0);
        chk("line_div5.vcount", int'(d_vcount), 2);

        // Two full frames of the small geometry with pix_en held high
        do_reset();
        fs_cnt  = 0;
        vs_cnt  = 0;
        last_fs = -1;
        pix_en  = 1'b1;
        for (int i = 1; i <= 384; i++) begin
            @(posedge sysclk);
            #1;
            if (s_frame_start) begin
                fs_cnt++;
                if (last_fs >= 0) chk("frames.fs_period", i - last_fs, 192);
                last_fs = i;
            end
            if (s_vsync == 1'b1) vs_cnt++;
        end
        pix_en = 1'b0;
        $display("txn frames: frame_starts=%0d vsync_pixels=%0d", fs_cnt, vs_cnt);
        chk("frames.fs_count", fs_cnt, 2);
        chk("frames.vsync_pixels", vs_cnt, 64);

        // Small geometry: first non-visible line stays blank throughout
        do_reset();
        pulses(1 + 6 * 16);
        chk("blank_line.s.vcount", int'(s_vcount), 6);
        chk("blank_line.s.hcount", int'(s_hcount), 0);
        for (int i = 0; i < 16; i++) begin
            chk("blank_line.s.video_on", int'(s_video_on), 0);
            pulses(1);
        end
        $display("txn blank_line: s h=%0d v=%0d", s_hcount, s_vcount);

        // Mid-line reset takes effect without a clock edge
        do_reset();
        pulses(301);
        chk("mid.d.hcount", int'(d_hcount), 300);
        #3;
        rst_n = 1'b0;
        #1;
        chk_d("mid_reset", 799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_s_reset("mid_reset");
        idle(2);
        rst_n = 1'b1;
        pulses(1);
        chk_d("after_reset", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("after_reset.s.frame_start", int'(s_frame_start), 1);

        // Random pulse spacing; the monitor checks holds and strobe widths
        do_reset();
        for (int i = 0; i < 700; i++) begin
            gap = int'($urandom_range(20, 1));
            pulses(1);
            if (gap > 1) idle(gap - 1);
        end
        $display("txn random: d h=%0d v=%0d s h=%0d v=%0d", d_hcount, d_vcount, s_hcount, s_vcount);

        idle(2);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
